// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer:
// state encoding, opcodes, ALU select codes, IR field positions.
package ctrl_pkg;

  localparam int CTRL_NUM_REGS = 16;
  localparam int CTRL_OPC_W    = 5;

  localparam int IR_OPC_HI = 31;
  localparam int IR_OPC_LO = 27;
  localparam int IR_RA_HI  = 26;
  localparam int IR_RA_LO  = 23;
  localparam int IR_RB_HI  = 22;
  localparam int IR_RB_LO  = 19;
  localparam int IR_RC_HI  = 18;
  localparam int IR_RC_LO  = 15;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  // Instruction classes sharing one T3..T7 step sequence.
  typedef enum logic [3:0] {
    K_ALU3, K_UNARY, K_MULDIV, K_IMM,
    K_LD, K_ST, K_NOP, K_HALT, K_BAD
  } op_kind_t;

  function automatic op_kind_t op_kind(logic [4:0] opc);
    op_kind_t k;
    k = K_BAD;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: k = K_ALU3;
      OP_NEG, OP_NOT:                 k = K_UNARY;
      OP_MUL, OP_DIV:                 k = K_MULDIV;
      OP_ADDI, OP_ANDI, OP_ORI:       k = K_IMM;
      OP_LD:                          k = K_LD;
      OP_ST:                          k = K_ST;
      OP_NOP:                         k = K_NOP;
      OP_HALT:                        k = K_HALT;
      default:                        k = K_BAD;
    endcase
    return k;
  endfunction

  // ld/st address math uses add.
  function automatic logic [3:0] op_alu(logic [4:0] opc);
    logic [3:0] a;
    a = ALU_ADD;
    case (opc)
      OP_SUB:          a = ALU_SUB;
      OP_AND, OP_ANDI: a = ALU_AND;
      OP_OR, OP_ORI:   a = ALU_OR;
      OP_SHR:          a = ALU_SHR;
      OP_SHL:          a = ALU_SHL;
      OP_ROR:          a = ALU_ROR;
      OP_ROL:          a = ALU_ROL;
      OP_MUL:          a = ALU_MUL;
      OP_DIV:          a = ALU_DIV;
      OP_NEG:          a = ALU_NEG;
      OP_NOT:          a = ALU_NOT;
      default:         a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Controller <-> datapath bundle. master = sequencer (drives strobes),
// slave = datapath (drives ir, mem_ready, stop).
interface ctrl_if
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = CTRL_NUM_REGS
);
  logic [31:0]         ir;
  logic                mem_ready;
  logic                stop;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic                PCin, PCout, IncPC, IRin;
  logic                MARin, MDRin, MDRout, MDRread;
  logic                mem_read, mem_write;
  logic                Yin, Zin, Zhighout, Zlowout;
  logic                HIin, LOin, Cout;
  logic [3:0]          ALUselect;
  logic                run, illegal;

  modport master (
    input  ir, mem_ready, stop,
    output reg_in, reg_out,
    output PCin, PCout, IncPC, IRin,
    output MARin, MDRin, MDRout, MDRread,
    output mem_read, mem_write,
    output Yin, Zin, Zhighout, Zlowout,
    output HIin, LOin, Cout,
    output ALUselect, run, illegal
  );

  modport slave (
    output ir, mem_ready, stop,
    input  reg_in, reg_out,
    input  PCin, PCout, IncPC, IRin,
    input  MARin, MDRin, MDRout, MDRread,
    input  mem_read, mem_write,
    input  Yin, Zin, Zhighout, Zlowout,
    input  HIin, LOin, Cout,
    input  ALUselect, run, illegal
  );
endinterface

// File: rtl/control_sequencer_reg_select_decoder.sv
// Picks Ra/Rb/Rc from IR via Gra/Grb/Grc and emits one-hot Rn in/out
// strobes. Ports: i_ir, i_gra/grb/grc, i_rin, i_rout -> o_reg_in, o_reg_out.
module reg_select_decoder
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = CTRL_NUM_REGS
) (
  input  logic [31:0]         i_ir,
  input  logic                i_gra,
  input  logic                i_grb,
  input  logic                i_grc,
  input  logic                i_rin,
  input  logic                i_rout,
  output logic [NUM_REGS-1:0] o_reg_in,
  output logic [NUM_REGS-1:0] o_reg_out
);
  logic [3:0]          w_sel;
  logic [NUM_REGS-1:0] w_onehot;
  logic                w_unused;

  assign w_sel =
    ({4{i_gra}} & i_ir[IR_RA_HI:IR_RA_LO]) |
    ({4{i_grb}} & i_ir[IR_RB_HI:IR_RB_LO]) |
    ({4{i_grc}} & i_ir[IR_RC_HI:IR_RC_LO]);

  assign w_onehot  = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_sel;
  assign o_reg_in  = i_rin  ? w_onehot : '0;
  assign o_reg_out = i_rout ? w_onehot : '0;

  assign w_unused = &{1'b0, i_ir[31:27], i_ir[14:0]};
endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch, decode, Moore strobes per state.
// Ports: clock, clear (sync, active-high), bus (ctrl_if.master).
// Macro CTRL_ILLEGAL_TRAP_EN: undefined opcode -> sticky illegal + HALT;
// without it an undefined opcode runs as nop and illegal is tied low.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = CTRL_NUM_REGS,
  parameter int OPC_W    = CTRL_OPC_W
) (
  input  logic     clock,
  input  logic     clear,
  ctrl_if.master   bus
);
  state_t     r_state, w_nxt;
  op_kind_t   w_kind;
  logic [4:0] w_opc;
  logic [3:0] w_alu_op;
  logic       w_last;
  logic       w_gra, w_grb, w_grc, w_rin, w_rout;
  logic       w_pcout, w_incpc, w_irin, w_marin;
  logic       w_mdrin, w_mdrout, w_mdrread;
  logic       w_mrd, w_mwr, w_yin, w_zin;
  logic       w_zhi, w_zlo, w_hiin, w_loin, w_cout;
  logic [3:0] w_alu;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       w_trap;
  logic       r_illegal;
`endif

  assign w_opc    = bus.ir[IR_OPC_HI -: OPC_W];
  assign w_kind   = op_kind(w_opc);
  assign w_alu_op = op_alu(w_opc);

  always_ff @(posedge clock) begin
    if (clear) r_state <= S_RESET;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_last    = 1'b0;
    w_gra     = 1'b0;
    w_grb     = 1'b0;
    w_grc     = 1'b0;
    w_rin     = 1'b0;
    w_rout    = 1'b0;
    w_pcout   = 1'b0;
    w_incpc   = 1'b0;
    w_irin    = 1'b0;
    w_marin   = 1'b0;
    w_mdrin   = 1'b0;
    w_mdrout  = 1'b0;
    w_mdrread = 1'b0;
    w_mrd     = 1'b0;
    w_mwr     = 1'b0;
    w_yin     = 1'b0;
    w_zin     = 1'b0;
    w_zhi     = 1'b0;
    w_zlo     = 1'b0;
    w_hiin    = 1'b0;
    w_loin    = 1'b0;
    w_cout    = 1'b0;
    w_alu     = ALU_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_trap    = 1'b0;
`endif
    case (r_state)
      S_RESET: w_nxt = S_T0;
      S_T0: begin
        w_pcout = 1'b1;
        w_marin = 1'b1;
        w_incpc = 1'b1;
        w_nxt   = S_T1;
      end
      S_T1: begin
        w_mrd     = 1'b1;
        w_mdrread = 1'b1;
        w_mdrin   = 1'b1;
        if (bus.mem_ready) w_nxt = S_T2;
      end
      S_T2: begin
        w_mdrout = 1'b1;
        w_irin   = 1'b1;
        w_nxt    = S_T3;
      end
      S_T3: begin
        w_nxt = S_T4;
        case (w_kind)
          K_ALU3, K_IMM, K_LD, K_ST: begin
            w_grb  = 1'b1;
            w_rout = 1'b1;
            w_yin  = 1'b1;
          end
          K_UNARY: begin
            w_grb  = 1'b1;
            w_rout = 1'b1;
            w_alu  = w_alu_op;
            w_zin  = 1'b1;
          end
          K_MULDIV: begin
            w_gra  = 1'b1;
            w_rout = 1'b1;
            w_yin  = 1'b1;
          end
          K_HALT: w_nxt = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          K_BAD: begin
            w_trap = 1'b1;
            w_nxt  = S_HALT;
          end
`endif
          default: w_last = 1'b1;
        endcase
      end
      S_T4: begin
        w_nxt = S_T5;
        case (w_kind)
          K_ALU3: begin
            w_grc  = 1'b1;
            w_rout = 1'b1;
            w_alu  = w_alu_op;
            w_zin  = 1'b1;
          end
          K_UNARY: begin
            w_zlo  = 1'b1;
            w_gra  = 1'b1;
            w_rin  = 1'b1;
            w_last = 1'b1;
          end
          K_MULDIV: begin
            w_grb  = 1'b1;
            w_rout = 1'b1;
            w_alu  = w_alu_op;
            w_zin  = 1'b1;
          end
          K_IMM, K_LD, K_ST: begin
            w_cout = 1'b1;
            w_alu  = w_alu_op;
            w_zin  = 1'b1;
          end
          default: w_nxt = S_T0;
        endcase
      end
      S_T5: begin
        w_nxt = S_T6;
        w_zlo = 1'b1;
        case (w_kind)
          K_ALU3, K_IMM: begin
            w_gra  = 1'b1;
            w_rin  = 1'b1;
            w_last = 1'b1;
          end
          K_MULDIV: w_loin  = 1'b1;
          K_LD, K_ST: w_marin = 1'b1;
          default: begin
            w_zlo = 1'b0;
            w_nxt = S_T0;
          end
        endcase
      end
      S_T6: begin
        w_nxt = S_T7;
        case (w_kind)
          K_MULDIV: begin
            w_zhi  = 1'b1;
            w_hiin = 1'b1;
            w_last = 1'b1;
          end
          K_LD: begin
            w_mrd     = 1'b1;
            w_mdrread = 1'b1;
            w_mdrin   = 1'b1;
            if (!bus.mem_ready) w_nxt = S_T6;
          end
          K_ST: begin
            w_gra   = 1'b1;
            w_rout  = 1'b1;
            w_mdrin = 1'b1;
          end
          default: w_nxt = S_T0;
        endcase
      end
      S_T7: begin
        w_nxt = S_T0;
        case (w_kind)
          K_LD: begin
            w_mdrout = 1'b1;
            w_gra    = 1'b1;
            w_rin    = 1'b1;
            w_last   = 1'b1;
          end
          K_ST: begin
            w_mwr = 1'b1;
            if (bus.mem_ready) w_last = 1'b1;
            else               w_nxt  = S_T7;
          end
          default: w_nxt = S_T0;
        endcase
      end
      S_HALT: w_nxt = S_HALT;
      default: w_nxt = S_RESET;
    endcase
    // stop is only honoured in the final T-state of an instruction.
    if (w_last) w_nxt = bus.stop ? S_HALT : S_T0;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clock) begin
    if (clear)       r_illegal <= 1'b0;
    else if (w_trap) r_illegal <= 1'b1;
  end
  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rsel (
    .i_ir      (bus.ir),
    .i_gra     (w_gra),
    .i_grb     (w_grb),
    .i_grc     (w_grc),
    .i_rin     (w_rin),
    .i_rout    (w_rout),
    .o_reg_in  (bus.reg_in),
    .o_reg_out (bus.reg_out)
  );

  assign bus.PCin      = 1'b0;
  assign bus.PCout     = w_pcout;
  assign bus.IncPC     = w_incpc;
  assign bus.IRin      = w_irin;
  assign bus.MARin     = w_marin;
  assign bus.MDRin     = w_mdrin;
  assign bus.MDRout    = w_mdrout;
  assign bus.MDRread   = w_mdrread;
  assign bus.mem_read  = w_mrd;
  assign bus.mem_write = w_mwr;
  assign bus.Yin       = w_yin;
  assign bus.Zin       = w_zin;
  assign bus.Zhighout  = w_zhi;
  assign bus.Zlowout   = w_zlo;
  assign bus.HIin      = w_hiin;
  assign bus.LOin      = w_loin;
  assign bus.Cout      = w_cout;
  assign bus.ALUselect = w_alu;
  assign bus.run       = (r_state != S_RESET) && (r_state != S_HALT);
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected output words are
// queued per driven cycle and compared on the following falling edge.
module tb_control_sequencer;
  import ctrl_pkg::*;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  ctrl_if #(.NUM_REGS(16)) bus();

  control_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  localparam logic [16:0] M_PCIN  = 17'd1 << 16;
  localparam logic [16:0] M_PCOUT = 17'd1 << 15;
  localparam logic [16:0] M_INCPC = 17'd1 << 14;
  localparam logic [16:0] M_IRIN  = 17'd1 << 13;
  localparam logic [16:0] M_MARIN = 17'd1 << 12;
  localparam logic [16:0] M_MDRIN = 17'd1 << 11;
  localparam logic [16:0] M_MDROUT= 17'd1 << 10;
  localparam logic [16:0] M_MDRRD = 17'd1 << 9;
  localparam logic [16:0] M_MRD   = 17'd1 << 8;
  localparam logic [16:0] M_MWR   = 17'd1 << 7;
  localparam logic [16:0] M_YIN   = 17'd1 << 6;
  localparam logic [16:0] M_ZIN   = 17'd1 << 5;
  localparam logic [16:0] M_ZHI   = 17'd1 << 4;
  localparam logic [16:0] M_ZLO   = 17'd1 << 3;
  localparam logic [16:0] M_HIIN  = 17'd1 << 2;
  localparam logic [16:0] M_LOIN  = 17'd1 << 1;
  localparam logic [16:0] M_COUT  = 17'd1;

  typedef struct {
    string       tag;
    logic [54:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [54:0] ex(
    logic [15:0] rin, logic [15:0] rout,
    logic [16:0] s, logic [3:0] alu,
    logic run, logic ill);
    return {rin, rout, s, alu, run, ill};
  endfunction

  function automatic logic [54:0] obs();
    return {bus.reg_in, bus.reg_out,
            bus.PCin, bus.PCout, bus.IncPC, bus.IRin,
            bus.MARin, bus.MDRin, bus.MDRout, bus.MDRread,
            bus.mem_read, bus.mem_write,
            bus.Yin, bus.Zin, bus.Zhighout, bus.Zlowout,
            bus.HIin, bus.LOin, bus.Cout,
            bus.ALUselect, bus.run, bus.illegal};
  endfunction

  task automatic check_eq(string tag, logic [54:0] got,
                          logic [54:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs(), e.v);
    end
  end

  // Drive one cycle's inputs and queue the outputs expected after the edge.
  task automatic go(logic clr, logic rdy, logic stp,
                    logic [54:0] v, string tag);
    exp_t e;
    clear         = clr;
    bus.mem_ready = rdy;
    bus.stop      = stp;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  logic [54:0] E_T0, E_T1, E_T2, E_Z, E_RUN;

  // From T0: enter T1, hold it for `waits` cycles, then T2.
  task automatic fetch(logic [31:0] irv, int waits);
    bus.ir = irv;
    go(1'b0, 1'b0, 1'b0, E_T1, "t1");
    for (int i = 0; i < waits; i++)
      go(1'b0, 1'b0, 1'b0, E_T1, "t1_wait");
    go(1'b0, 1'b1, 1'b0, E_T2, "t2");
  endtask

  initial begin
    E_T0  = ex(0, 0, M_PCOUT | M_MARIN | M_INCPC, 0, 1, 0);
    E_T1  = ex(0, 0, M_MRD | M_MDRRD | M_MDRIN, 0, 1, 0);
    E_T2  = ex(0, 0, M_MDROUT | M_IRIN, 0, 1, 0);
    E_Z   = '0;
    E_RUN = ex(0, 0, 0, 0, 1, 0);
    bus.ir        = 32'h0;
    bus.mem_ready = 1'b0;
    bus.stop      = 1'b0;

    go(1'b1, 1'b0, 1'b0, E_Z, "rst0");
    go(1'b1, 1'b0, 1'b0, E_Z, "rst1");
    go(1'b0, 1'b0, 1'b0, E_T0, "rel_t0");

    // add R1,R2,R3; stop in T3 must be ignored
    fetch(32'h18918000, 0);
    go(0, 0, 0, ex(0, 16'h0004, M_YIN, 0, 1, 0), "add_t3");
    go(0, 0, 1, ex(0, 16'h0008, M_ZIN, 0, 1, 0), "add_t4");
    go(0, 0, 0, ex(16'h0002, 0, M_ZLO, 0, 1, 0), "add_t5");
    go(0, 0, 0, E_T0, "add_t0");

    // not R1,R2 with two fetch wait cycles
    fetch(32'h90900000, 2);
    go(0, 0, 0, ex(0, 16'h0004, M_ZIN, 4'd11, 1, 0), "not_t3");
    go(0, 0, 0, ex(16'h0002, 0, M_ZLO, 0, 1, 0), "not_t4");
    go(0, 0, 0, E_T0, "not_t0");

    // andi R1,R2,C
    fetch(32'h68900000, 0);
    go(0, 0, 0, ex(0, 16'h0004, M_YIN, 0, 1, 0), "andi_t3");
    go(0, 0, 0, ex(0, 0, M_COUT | M_ZIN, 4'd2, 1, 0), "andi_t4");
    go(0, 0, 0, ex(16'h0002, 0, M_ZLO, 0, 1, 0), "andi_t5");
    go(0, 0, 0, E_T0, "andi_t0");

    // ld R1 with three wait cycles in T6
    fetch(32'h00900000, 0);
    go(0, 0, 0, ex(0, 16'h0004, M_YIN, 0, 1, 0), "ld_t3");
    go(0, 0, 0, ex(0, 0, M_COUT | M_ZIN, 0, 1, 0), "ld_t4");
    go(0, 0, 0, ex(0, 0, M_ZLO | M_MARIN, 0, 1, 0), "ld_t5");
    go(0, 0, 0, E_T1, "ld_t6");
    for (int i = 0; i < 3; i++)
      go(0, 0, 0, E_T1, "ld_t6_wait");
    go(0, 1, 0, ex(16'h0002, 0, M_MDROUT, 0, 1, 0), "ld_t7");
    go(0, 0, 0, E_T0, "ld_t0");

    // mul R4,R5
    fetch(32'h7A280000, 0);
    go(0, 0, 0, ex(0, 16'h0010, M_YIN, 0, 1, 0), "mul_t3");
    go(0, 0, 0, ex(0, 16'h0020, M_ZIN, 4'd8, 1, 0), "mul_t4");
    go(0, 0, 0, ex(0, 0, M_ZLO | M_LOIN, 0, 1, 0), "mul_t5");
    go(0, 0, 0, ex(0, 0, M_ZHI | M_HIIN, 0, 1, 0), "mul_t6");
    go(0, 0, 0, E_T0, "mul_t0");

    // st R1, clear hits during the T7 wait
    fetch(32'h10900000, 0);
    go(0, 0, 0, ex(0, 16'h0004, M_YIN, 0, 1, 0), "st_t3");
    go(0, 0, 0, ex(0, 0, M_COUT | M_ZIN, 0, 1, 0), "st_t4");
    go(0, 0, 0, ex(0, 0, M_ZLO | M_MARIN, 0, 1, 0), "st_t5");
    go(0, 0, 0, ex(0, 16'h0002, M_MDRIN, 0, 1, 0), "st_t6");
    go(0, 0, 0, ex(0, 0, M_MWR, 0, 1, 0), "st_t7");
    go(0, 0, 0, ex(0, 0, M_MWR, 0, 1, 0), "st_t7_wait");
    go(1, 0, 0, E_Z, "st_clr");
    go(0, 0, 0, E_T0, "st_rel_t0");

    // halt opcode, then 20 idle cycles
    fetch(32'hD8000000, 0);
    go(0, 0, 0, E_RUN, "halt_t3");
    go(0, 0, 0, E_Z, "halt_enter");
    for (int i = 0; i < 20; i++)
      go(0, 1'($urandom_range(1)), 1'($urandom_range(1)),
         E_Z, "halt_stay");
    go(1, 0, 0, E_Z, "halt_clr");
    go(0, 0, 0, E_T0, "halt_rel_t0");

    // nop with stop high in its last T-state
    fetch(32'hD0000000, 0);
    go(0, 0, 0, E_RUN, "nop_t3");
    go(0, 0, 1, E_Z, "nop_stop_halt");
    go(1, 0, 0, E_Z, "nop_clr");
    go(0, 0, 0, E_T0, "nop_rel_t0");

    // undefined opcode 11111
    fetch(32'hF8000000, 0);
    go(0, 0, 0, E_RUN, "ill_t3");
`ifdef CTRL_ILLEGAL_TRAP_EN
    go(0, 0, 0, ex(0, 0, 0, 0, 0, 1), "ill_halt");
    go(0, 0, 0, ex(0, 0, 0, 0, 0, 1), "ill_sticky");
    go(1, 0, 0, E_Z, "ill_clr");
    go(0, 0, 0, E_T0, "ill_rel_t0");
`else
    go(0, 0, 0, E_T0, "ill_nop_t0");
`endif

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit datapath. Fetches instructions through PC/MAR/MDR, decodes the IR, and steps a T-state machine. Each state drives the datapath's one-hot register strobes, special-register strobes, ALU select and memory handshake. It replaces the manual control inputs currently driven by the testbench at the datapath top level.

## Interface
- NUM_REGS, 16, general registers; width of reg_in/reg_out
- OPC_W, 5, opcode width, IR[31:27]
- clock  input  1  system clock, all state on rising edge
- clear  input  1  synchronous, active-high reset
- ir  input  32  IR register contents (Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15])
- mem_ready  input  1  memory completes the current read/write this cycle
- stop  input  1  halt request, sampled at instruction end
- reg_in / reg_out  output  NUM_REGS each  one-hot Rn in / Rn out strobes
- PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout  output  1 each  datapath strobes
- MDRread  output  1  MDR selects memory data (1) or bus (0)
- mem_read, mem_write  output  1 each  memory request, held until mem_ready
- Yin, Zin, Zhighout, Zlowout, HIin, LOin, Cout  output  1 each  datapath strobes
- ALUselect  output  4  0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shl, 6 ror, 7 rol, 8 mul, 9 div, 10 neg, 11 not
- run  output  1  high unless in RESET or HALT
- illegal  output  1  undefined opcode trapped (macro only)

## Operation
- States: RESET, T0, T1, T2, T3..T7, HALT. Moore outputs decoded from state and ir. Unlisted outputs are 0; ALUselect defaults to 0 (add).
- RESET→T0 unconditionally.
- T0: PCout, MARin, IncPC.
- T1: mem_read, MDRread, MDRin. Wait here until mem_ready.
- T2: MDRout, IRin. Go to T3.
- R-type ALU ops (add, sub, and, or, shr, shl, ror, rol):
  - T3: Rb out, Yin.
  - T4: Rc out, ALUselect=op, Zin.
  - T5: Zlowout, Ra in.
- neg/not: T3 Rb out, ALUselect=op, Zin; T4 Zlowout, Ra in.
- mul/div: T3 Ra out, Yin; T4 Rb out, ALUselect, Zin; T5 Zlowout, LOin; T6 Zhighout, HIin.
- addi/andi/ori: T3 Rb out, Yin; T4 Cout, ALUselect, Zin; T5 Zlowout, Ra in.
- ld/st address phase: T3 Rb out, Yin; T4 Cout, add, Zin; T5 Zlowout, MARin.
  - ld: T6 mem_read, MDRread, MDRin, wait until mem_ready; T7 MDRout, Ra in.
  - st: T6 Ra out, MDRin (MDRread=0); T7 mem_write, wait until mem_ready.
- nop: T3 with no strobes. halt: T3 then HALT.
- Opcodes: ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01001, ror 01010, rol 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, nop 11010, halt 11011.
- Last T-state of any instruction goes to T0, or to HALT if stop=1 in that cycle.
- HALT is absorbing; only clear exits it.

## Timing
- Reset: while clear is high at an edge, state becomes RESET and all outputs are 0, including run and illegal. This applies from any state, including mid-wait.
- Zero-wait cycle counts from T0: ALU R-type 6, neg/not 5, immediate 6, mul/div 7, ld 8, st 8, nop 4.
- Each cycle mem_ready is low in T1, ld-T6 or st-T7 adds one cycle. All outputs are held constant during the wait.
- Memory requests are level signals: mem_read/mem_write drop the cycle after mem_ready is sampled high.
- stop arriving mid-instruction is not latched; it must be high in the final T-state to take effect.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an undefined opcode in T3 sets illegal=1 and enters HALT. illegal is sticky until clear.
- Undefined: an undefined opcode executes as nop. illegal is tied to 0.

## Structure
- ctrl_pkg holds: state enum, opcode localparams, ALUselect codes, IR field bit positions.
- One sub-module, reg_select_decoder: turns ir plus Gra/Grb/Grc and Rin/Rout requests into the one-hot reg_in/reg_out vectors.

## Test plan
- clear high 2 cycles → all outputs 0, run=0. First cycle after release: RESET. Next cycle T0: PCout=MARin=IncPC=1.
- ir=0x18918000 (add R1,R2,R3), mem_ready=1 → T3 reg_out=0x0004, Yin; T4 reg_out=0x0008, ALUselect=0, Zin; T5 Zlowout, reg_in=0x0002; T0 six cycles after the first T0.
- ld R1 (ir=0x00900000), mem_ready low 3 cycles in T6 → T6 held 4 cycles with mem_read/MDRin=1; then T7 MDRout, reg_in=0x0002.
- mul R4,R5 (ir=0x7A280000) → T5 Zlowout+LOin, T6 Zhighout+HIin; reg_in=0 throughout.
- halt opcode → run=0 from the cycle after T3, stays in HALT 20 cycles. clear → RESET then T0.
- opcode 11111: with macro → illegal=1, HALT. Without macro → nop, back to T0 after 4 cycles. Also: clear asserted during st-T7 wait → next cycle mem_write=0.
